cu_data_read_engine_multi_channel: RTL

Parametrised multi-channel read command engine for the compute unit. Each of NUM_CHANNELS channels is loaded with a base address and an element count, then issues cacheline read commands over that array. A round-robin arbiter merges the channels onto one command port, gated by a global outstanding-credit limit. Responses are counted back per channel, and each channel flags completion when every requested element has been returned.

---
 rtl/cu_data_read_engine_multi_channel.sv | 242 ++++++++++++++++++++++++
 1 files changed

// File: rtl/cu_data_read_engine_multi_channel.sv
// cu_data_read_engine_multi_channel
// Multi-channel cacheline read command engine. Each channel holds one job
// (base address + element count) and walks it in CL_ELEMS-element
// cacheline commands. A round-robin arbiter merges the channels onto a single
// registered command port, throttled by cmd_alfull and a global
// outstanding-command credit. Responses are accumulated per channel, and a
// channel reports done once every requested element has come back.
//
// Ports:
//   clock, rst          rising-edge clock, synchronous active-high reset
//   enabled_in          global enable (registered one cycle before use)
//   cfg_*               job load strobe / target channel / job attributes
//   cfg_error           one-cycle pulse: load hit a busy (ISSUE/DRAIN) channel
//   cmd_alfull          downstream command buffer almost-full
//   cmd_*               registered read command (valid one cycle per command)
//   rsp_*               read response strobe / channel / element count
//   done_count          per-channel returned-element counters, ch0 in LSBs
//   channel_done        per-channel level, channel is in DONE
//   outstanding         global issued-but-unanswered command count
//   rsp_error           sticky: response to an idle/done channel or with
//                       nothing outstanding
//
// Channel states:
//   state    | meaning
//   ---------+------------------------------------------------------------
//   IDLE     | no job since reset; accepts a load
//   ISSUE    | job loaded, elements remain to be requested
//   DRAIN    | every command issued, waiting for responses
//   DONE     | all elements returned; accepts a new load
module cu_data_read_engine_multi_channel #(
    parameter int NUM_CHANNELS    = 4,
    parameter int CH_W            = $clog2(NUM_CHANNELS),
    parameter int ADDR_W          = 64,
    parameter int SIZE_W          = 32,
    parameter int CL_ELEMS        = 16,
    parameter int CL_BYTES        = 128,
    parameter int MAX_OUTSTANDING = 32,
    parameter int OUT_W           = $clog2(MAX_OUTSTANDING + 1),
    parameter int RS_W            = $clog2(CL_ELEMS + 1)
) (
    input  logic                           clock,
    input  logic                           rst,
    input  logic                           enabled_in,
    input  logic                           cfg_valid,
    input  logic [CH_W-1:0]                cfg_channel,
    input  logic [ADDR_W-1:0]              cfg_base,
    input  logic [SIZE_W-1:0]              cfg_size,
    input  logic [2:0]                     cfg_abt,
    input  logic                           cfg_cached,
    output logic                           cfg_error,
    input  logic                           cmd_alfull,
    output logic                           cmd_valid,
    output logic [CH_W-1:0]                cmd_channel,
    output logic [ADDR_W-1:0]              cmd_address,
    output logic [RS_W-1:0]                cmd_real_size,
    output logic                           cmd_cached,
    output logic [2:0]                     cmd_abt,
    input  logic                           rsp_valid,
    input  logic [CH_W-1:0]                rsp_channel,
    input  logic [RS_W-1:0]                rsp_real_size,
    output logic [NUM_CHANNELS*SIZE_W-1:0] done_count,
    output logic [NUM_CHANNELS-1:0]        channel_done,
    output logic [OUT_W-1:0]               outstanding,
    output logic                           rsp_error
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } ch_state_e;

    ch_state_e          state_q     [NUM_CHANNELS];
    logic [ADDR_W-1:0]  base_q      [NUM_CHANNELS];
    logic [ADDR_W-1:0]  offset_q    [NUM_CHANNELS];
    logic [SIZE_W-1:0]  remaining_q [NUM_CHANNELS];
    logic [SIZE_W-1:0]  size_q      [NUM_CHANNELS];
    logic [2:0]         abt_q       [NUM_CHANNELS];
    logic               cached_q    [NUM_CHANNELS];
    logic [SIZE_W-1:0]  done_cnt_q  [NUM_CHANNELS];
    logic [SIZE_W-1:0]  done_cnt_d  [NUM_CHANNELS];

    logic               enabled_q;
    logic [CH_W-1:0]    rr_q;
    logic [OUT_W-1:0]   outstanding_q;
    logic               cfg_error_q;
    logic               rsp_error_q;
    logic               cmd_valid_q;
    logic [CH_W-1:0]    cmd_channel_q;
    logic [ADDR_W-1:0]  cmd_address_q;
    logic [RS_W-1:0]    cmd_real_size_q;
    logic               cmd_cached_q;
    logic [2:0]         cmd_abt_q;

    logic               can_issue;
    logic               grant_vld;
    logic [CH_W-1:0]    grant_ch;
    logic [CH_W-1:0]    idx;
    logic [RS_W-1:0]    real_size_d;
    logic               rsp_ok;
    logic               cfg_hit;
    logic               cfg_busy;

    // Arbitration and response qualification. The search walks from the
    // farthest offset down to the pointer so the nearest eligible channel
    // at or after rr_q is the last (winning) assignment.
    always_comb begin
        can_issue = enabled_q && !cmd_alfull &&
                    (outstanding_q < OUT_W'(MAX_OUTSTANDING));
        grant_vld = 1'b0;
        grant_ch  = '0;
        idx       = '0;
        for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
            idx = rr_q + CH_W'(i);
            if (can_issue && (state_q[idx] == ST_ISSUE)) begin
                grant_vld = 1'b1;
                grant_ch  = idx;
            end
        end

        if (remaining_q[grant_ch] > SIZE_W'(CL_ELEMS))
            real_size_d = RS_W'(CL_ELEMS);
        else
            real_size_d = RS_W'(remaining_q[grant_ch]);

        rsp_ok = rsp_valid &&
                 ((state_q[rsp_channel] == ST_ISSUE) ||
                  (state_q[rsp_channel] == ST_DRAIN)) &&
                 (outstanding_q != '0);

        cfg_hit  = cfg_valid && enabled_q;
        cfg_busy = (state_q[cfg_channel] == ST_ISSUE) ||
                   (state_q[cfg_channel] == ST_DRAIN);

        for (int c = 0; c < NUM_CHANNELS; c++) begin
            done_cnt_d[c] = done_cnt_q[c];
            if (rsp_ok && (rsp_channel == CH_W'(c)))
                done_cnt_d[c] = done_cnt_q[c] + SIZE_W'(rsp_real_size);
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            enabled_q       <= 1'b0;
            rr_q            <= '0;
            outstanding_q   <= '0;
            cfg_error_q     <= 1'b0;
            rsp_error_q     <= 1'b0;
            cmd_valid_q     <= 1'b0;
            cmd_channel_q   <= '0;
            cmd_address_q   <= '0;
            cmd_real_size_q <= '0;
            cmd_cached_q    <= 1'b0;
            cmd_abt_q       <= '0;
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                state_q[c]     <= ST_IDLE;
                base_q[c]      <= '0;
                offset_q[c]    <= '0;
                remaining_q[c] <= '0;
                size_q[c]      <= '0;
                abt_q[c]       <= '0;
                cached_q[c]    <= 1'b0;
                done_cnt_q[c]  <= '0;
            end
        end else begin
            enabled_q   <= enabled_in;
            cfg_error_q <= cfg_hit && cfg_busy;
            cmd_valid_q <= grant_vld;

            if (grant_vld) begin
                cmd_channel_q   <= grant_ch;
                cmd_address_q   <= base_q[grant_ch] + offset_q[grant_ch];
                cmd_real_size_q <= real_size_d;
                cmd_cached_q    <= cached_q[grant_ch];
                cmd_abt_q       <= abt_q[grant_ch];
                rr_q            <= grant_ch + CH_W'(1);
            end

            // Simultaneous issue and response cancel out.
            if (grant_vld && !rsp_ok)
                outstanding_q <= outstanding_q + OUT_W'(1);
            else if (!grant_vld && rsp_ok)
                outstanding_q <= outstanding_q - OUT_W'(1);

            if (rsp_valid && !rsp_ok)
                rsp_error_q <= 1'b1;

            for (int c = 0; c < NUM_CHANNELS; c++) begin
                done_cnt_q[c] <= done_cnt_d[c];
                case (state_q[c])
                    ST_IDLE, ST_DONE: begin
                        if (cfg_hit && (cfg_channel == CH_W'(c))) begin
                            base_q[c]      <= cfg_base;
                            offset_q[c]    <= '0;
                            remaining_q[c] <= cfg_size;
                            size_q[c]      <= cfg_size;
                            abt_q[c]       <= cfg_abt;
                            cached_q[c]    <= cfg_cached;
                            done_cnt_q[c]  <= '0;
                            state_q[c]     <= (cfg_size == '0) ? ST_DONE : ST_ISSUE;
                        end
                    end
                    ST_ISSUE: begin
                        if (grant_vld && (grant_ch == CH_W'(c))) begin
                            remaining_q[c] <= remaining_q[c] - SIZE_W'(real_size_d);
                            offset_q[c]    <= offset_q[c] + ADDR_W'(CL_BYTES);
                            if (remaining_q[c] == SIZE_W'(real_size_d))
                                state_q[c] <= ST_DRAIN;
                        end
                    end
                    ST_DRAIN: begin
                        // Compare against the post-response count so done
                        // appears together with the final count update.
                        if (done_cnt_d[c] == size_q[c])
                            state_q[c] <= ST_DONE;
                    end
                    default: state_q[c] <= ST_IDLE;
                endcase
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_CHANNELS; g++) begin : g_out
            assign done_count[g*SIZE_W +: SIZE_W] = done_cnt_q[g];
            assign channel_done[g]                = (state_q[g] == ST_DONE);
        end
    endgenerate

    assign cfg_error     = cfg_error_q;
    assign rsp_error     = rsp_error_q;
    assign outstanding   = outstanding_q;
    assign cmd_valid     = cmd_valid_q;
    assign cmd_channel   = cmd_channel_q;
    assign cmd_address   = cmd_address_q;
    assign cmd_real_size = cmd_real_size_q;
    assign cmd_cached    = cmd_cached_q;
    assign cmd_abt       = cmd_abt_q;

endmodule
